// File: rtl/bcd2bin.sv
// -----------------------------------------------------------------------------
// bcd2bin - sequential 5-digit BCD to 16-bit binary converter.
//
// This module performs reverse double-dabble and produces one result bit per
// clock. A 37-bit work register {bcd[19:0], acc[16:0]} is shifted right 17
// times. After each shift, every BCD digit that is 8 or more is reduced by 3.
// When the shifts finish, acc holds the binary value. The value can reach
// 99999, so acc[16] is reported as overflow.
//
// Ports:
//   clk      in   1   rising-edge clock
//   reset_n  in   1   asynchronous active-low reset
//   start    in   1   conversion request, sampled only when not busy
//   bcd_in   in  20   packed BCD, digit 4 in [19:16] ... digit 0 in [3:0]
//   busy     out  1   conversion in progress (SHIFT state)
//   done     out  1   one-cycle pulse, results valid from this cycle on
//   bin_out  out 16   low 16 bits of the converted value (held until next done)
//   ovf      out  1   converted value exceeds 65535 (held until next done)
//   err      out  1   invalid BCD digit seen (held until next done)
//
// Optional feature:
//   BCD2BIN_DIGIT_CHECK_EN - When this macro is defined, a request that
//   contains a digit greater than 9 skips the shift phase. The result is
//   reported one cycle later with err=1, bin_out=0 and ovf=0. When the macro
//   is undefined, err is tied low and invalid digits pass through the normal
//   algorithm.
// -----------------------------------------------------------------------------
module bcd2bin (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [19:0] bcd_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] bin_out,
    output logic        ovf,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The counter value that marks the 17th (last) shift.
    localparam logic [4:0] LAST_ITER = 5'd16;

    state_t      state;
    state_t      state_nxt;
    logic [36:0] work;
    logic [36:0] work_nxt;
    logic [36:0] shifted;
    logic [4:0]  cnt;
    logic [4:0]  cnt_nxt;
    logic [15:0] bin_nxt;
    logic        ovf_nxt;
    logic        bad_digit;
    // The LSB of the work register is always shifted out and never read.
    logic        unused_lsb;

    assign unused_lsb = work[0];

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic err_q;
    logic err_nxt;

    always_comb begin
        bad_digit = 1'b0;
        for (int d = 0; d < 5; d++) begin
            if (bcd_in[4*d +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign bad_digit = 1'b0;
    assign err       = 1'b0;
`endif

    // One iteration: shift right, then correct every digit that is 8 or more.
    // A corrected digit is always at least 5, so the 4-bit subtract never wraps
    // in practice.
    always_comb begin
        shifted = {1'b0, work[36:1]};
        for (int d = 0; d < 5; d++) begin
            if (shifted[17 + 4*d +: 4] >= 4'd8) begin
                shifted[17 + 4*d +: 4] = shifted[17 + 4*d +: 4] - 4'd3;
            end
        end
    end

    // NOTE: every signal is given a default before the case statement, so no
    // path can leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        work_nxt  = work;
        cnt_nxt   = cnt;
        bin_nxt   = bin_out;
        ovf_nxt   = ovf;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        err_nxt   = err_q;
`endif
        case (state)
            // A start request is accepted from DONE as well as IDLE, so two
            // conversions can run back to back without an idle cycle.
            IDLE, DONE: begin
                if (start) begin
                    work_nxt = {bcd_in, 17'd0};
                    cnt_nxt  = '0;
                    if (bad_digit) begin
                        state_nxt = DONE;
                        bin_nxt   = '0;
                        ovf_nxt   = 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                        err_nxt   = 1'b1;
`endif
                    end else begin
                        state_nxt = SHIFT;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            SHIFT: begin
                work_nxt = shifted;
                if (cnt == LAST_ITER) begin
                    // The result comes straight from the last shift, so it is
                    // registered on the same edge that enters DONE.
                    state_nxt = DONE;
                    bin_nxt   = shifted[15:0];
                    ovf_nxt   = shifted[16];
`ifdef BCD2BIN_DIGIT_CHECK_EN
                    err_nxt   = 1'b0;
`endif
                end else begin
                    cnt_nxt = cnt + 5'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    // All flops read the values from before the edge, so the result does not
    // depend on the order in which the blocks are evaluated.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            work    <= '0;
            cnt     <= '0;
            bin_out <= '0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_nxt;
            work    <= work_nxt;
            cnt     <= cnt_nxt;
            bin_out <= bin_nxt;
            ovf     <= ovf_nxt;
        end
    end

`ifdef BCD2BIN_DIGIT_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_nxt;
        end
    end
`endif

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_bcd2bin.sv
// -----------------------------------------------------------------------------
// tb_bcd2bin - self-checking bench for bcd2bin.
//
// Inputs are driven and outputs sampled on the falling clock edge. Latency is
// the index of the first falling edge after the accepting rising edge at which
// done is seen. In the normal case this is 18 and busy is seen on the 17 falling
// edges before it. The reference model sums the decimal digits with plain
// integer arithmetic.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bcd2bin;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic [19:0] bcd_in  = '0;
    logic        busy;
    logic        done;
    logic [15:0] bin_out;
    logic        ovf;
    logic        err;

    int          errors = 0;
    int          checks = 0;

    // Last result the model knows the DUT is holding (used for hold checks).
    logic [15:0] prev_bin   = '0;
    logic        prev_ovf   = 1'b0;
    logic        prev_known = 1'b1;

    bcd2bin dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .ovf     (ovf),
        .err     (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int bcd_value(input logic [19:0] v);
        int acc;
        acc = 0;
        for (int d = 4; d >= 0; d--) begin
            acc = acc * 10 + int'(v[4*d +: 4]);
        end
        return acc;
    endfunction

    function automatic logic has_bad_digit(input logic [19:0] v);
        logic bad;
        bad = 1'b0;
        for (int d = 0; d < 5; d++) begin
            if (v[4*d +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic logic [19:0] to_bcd(input int n);
        logic [19:0] r;
        int          m;
        r = '0;
        m = n;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    // One full conversion. The task is entered at a falling edge with the DUT
    // idle and returns at a falling edge with the DUT idle again.
    task automatic run_conv(input logic [19:0] v);
        int          val;
        int          exp_lat;
        int          lat;
        int          busy_cycles;
        logic        bad;
        logic        check_result;
        logic [15:0] exp_bin;
        logic        exp_ovf;
        logic        exp_err;

        val          = bcd_value(v);
        bad          = has_bad_digit(v);
        exp_lat      = 18;
        exp_bin      = val[15:0];
        exp_ovf      = (val > 65535);
        exp_err      = 1'b0;
        check_result = !bad;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        if (bad) begin
            exp_lat      = 1;
            exp_bin      = '0;
            exp_ovf      = 1'b0;
            exp_err      = 1'b1;
            check_result = 1'b1;
        end
`endif

        bcd_in = v;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        bcd_in = 20'($urandom);   // capture must have happened on the edge

        if (exp_lat > 1 && prev_known) begin
            checks++;
            if (bin_out !== prev_bin || ovf !== prev_ovf) begin
                errors++;
                $display("FAIL hold_on_start %05h: bin_out=%04h ovf=%0b expected %04h/%0b",
                         v, bin_out, ovf, prev_bin, prev_ovf);
            end
        end

        lat         = 0;
        busy_cycles = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (busy === 1'b1) busy_cycles++;
        end

        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL latency %05h: got %0d expected %0d (0 = timeout)", v, lat, exp_lat);
        end
        checks++;
        if (busy_cycles != exp_lat - 1) begin
            errors++;
            $display("FAIL busy_cycles %05h: got %0d expected %0d", v, busy_cycles, exp_lat - 1);
        end
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL err %05h: got %0b expected %0b", v, err, exp_err);
        end
        if (check_result) begin
            checks++;
            if (bin_out !== exp_bin) begin
                errors++;
                $display("FAIL bin_out %05h: got %04h expected %04h", v, bin_out, exp_bin);
            end
            checks++;
            if (ovf !== exp_ovf) begin
                errors++;
                $display("FAIL ovf %05h: got %0b expected %0b", v, ovf, exp_ovf);
            end
        end

        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse %05h: done=%0b busy=%0b expected 0/0", v, done, busy);
        end

        prev_bin   = exp_bin;
        prev_ovf   = exp_ovf;
        prev_known = check_result;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bin_out !== 16'h0000 || ovf !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%0b done=%0b bin_out=%04h ovf=%0b err=%0b expected all 0",
                     busy, done, bin_out, ovf, err);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%0b done=%0b expected 0/0", busy, done);
        end
        prev_bin   = '0;
        prev_ovf   = 1'b0;
        prev_known = 1'b1;
    endtask

    task automatic test_boundaries();
        run_conv(20'h12345);
        run_conv(20'h65535);
        run_conv(20'h65536);
        run_conv(20'h99999);
        run_conv(20'h00000);
        run_conv(20'h00009);
    endtask

    task automatic test_random();
        logic [19:0] v;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 5) == 0) v = 20'($urandom);
            else                           v = to_bcd(int'($urandom_range(0, 99999)));
            run_conv(v);
        end
    endtask

    task automatic test_back_to_back();
        int gap;
        int first;
        bcd_in = 20'h00001;
        start  = 1'b1;
        first  = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                first = k;
                break;
            end
        end
        checks++;
        if (first != 18) begin
            errors++;
            $display("FAIL b2b_first_latency: got %0d expected 18", first);
        end
        checks++;
        if (bin_out !== 16'h0001) begin
            errors++;
            $display("FAIL b2b_first_result: got %04h expected 0001", bin_out);
        end
        bcd_in = 20'h00255;       // presented on the DONE cycle, start still high
        @(negedge clk);
        start  = 1'b0;
        bcd_in = 20'h77777;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_reaccept: busy=%0b expected 1", busy);
        end
        gap = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (done === 1'b1) begin
                gap = k;
                break;
            end
        end
        checks++;
        if (gap != 18) begin
            errors++;
            $display("FAIL b2b_gap: got %0d expected 18", gap);
        end
        checks++;
        if (bin_out !== 16'h00FF || ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_result: got %04h/%0b expected 00FF/0", bin_out, ovf);
        end
        @(negedge clk);
        prev_bin   = 16'h00FF;
        prev_ovf   = 1'b0;
        prev_known = 1'b1;
    endtask

    task automatic test_busy_ignore();
        int lat;
        bcd_in = 20'h00777;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        lat    = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 5) begin
                bcd_in = 20'h00123;
                start  = 1'b1;
            end else begin
                start  = 1'b0;
            end
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (lat != 18 || bin_out !== 16'h0309) begin
            errors++;
            $display("FAIL busy_ignore_result: lat=%0d bin_out=%04h expected 18/0309", lat, bin_out);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL busy_ignore_no_queue: busy=%0b done=%0b expected 0/0", busy, done);
            end
        end
        prev_bin   = 16'h0309;
        prev_ovf   = 1'b0;
        prev_known = 1'b1;
    endtask

    task automatic test_reset_abort();
        int stray;
        bcd_in = 20'h40000;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (8) @(negedge clk);  // iteration 8 has just been performed
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bin_out !== 16'h0000 || ovf !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL abort_immediate: busy=%0b done=%0b bin_out=%04h ovf=%0b err=%0b expected all 0",
                     busy, done, bin_out, ovf, err);
        end
        @(negedge clk);
        reset_n = 1'b1;
        stray   = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL abort_no_done: %0d active cycles expected 0", stray);
        end
        prev_bin   = '0;
        prev_ovf   = 1'b0;
        prev_known = 1'b1;
        run_conv(20'h40000);
        checks++;
        if (bin_out !== 16'h9C40) begin
            errors++;
            $display("FAIL abort_reconvert: got %04h expected 9C40", bin_out);
        end
    endtask

    task automatic test_digit_check();
        // The model in run_conv decides the latency, err and result for the
        // build that is being compiled.
        run_conv(20'h0A000);
        run_conv(20'h00042);
        checks++;
        if (bin_out !== 16'h002A || err !== 1'b0) begin
            errors++;
            $display("FAIL digit_check_recover: got %04h err=%0b expected 002A/0", bin_out, err);
        end
    endtask

    initial begin
        test_reset();
        test_boundaries();
        test_back_to_back();
        test_busy_ignore();
        test_reset_abort();
        test_digit_check();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
